// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit processor: instruction fields, opcodes,
// ALU operation codes and the control sequencer state type.
package cpu8_pkg;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 5;
    localparam int RD_HI  = 4;
    localparam int RD_LO  = 3;
    localparam int RS_HI  = 2;
    localparam int RS_LO  = 0;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_BEQZ = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // A branch-if-zero with a zero offset would spin forever, so it encodes HALT.
    function automatic logic is_halt(input logic [7:0] ins);
        return (ins[OPC_HI:OPC_LO] == OP_BEQZ) && (ins[RS_HI:RS_LO] == 3'b000);
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the sequencer and the datapath / memories.
// master = sequencer side, slave = datapath / memory side.
interface mc_control_fsm_if #(parameter int CNT_W = 16);
    logic [7:0]       instr;
    logic             alu_zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_en;
    logic             pc_en;
    logic             pc_src_br;
    logic [1:0]       alu_op;
    logic             alu_src_imm;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_we;
    logic             wb_sel_mem;
    logic             halted;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_en, pc_en, pc_src_br, alu_op, alu_src_imm,
               dmem_req, dmem_we, reg_we, wb_sel_mem, halted, retired
    );

    modport slave (
        output instr, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_en, pc_en, pc_src_br, alu_op, alu_src_imm,
               dmem_req, dmem_we, reg_we, wb_sel_mem, halted, retired
    );
endinterface

// File: rtl/retire_counter.sv
// Saturating count of retired instructions, exposed for debug.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer: fetch / decode / exec / mem / writeback,
// driving every datapath enable and select from state and opcode.
module mc_control_fsm
    import cpu8_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_control_fsm_if.master   bus
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] opc;
    logic       retire;

    logic       imem_req;
    logic       ir_en;
    logic       pc_en;
    logic       pc_src_br;
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       wb_sel_mem;
    logic       halted;

    assign opc = bus.instr[OPC_HI:OPC_LO];

    // The destination register is steered by the datapath, not the sequencer.
    logic unused_rd;
    assign unused_rd = ^bus.instr[RD_HI:RD_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (bus.imem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = is_halt(bus.instr) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (opc)
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_BEQZ:      state_nxt = S_FETCH;
                    default:      state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) state_nxt = (opc == OP_ST) ? S_FETCH : S_WB;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously; gating with rst_n keeps the fetch
    // request quiet while reset is still held.
    always_comb begin
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        pc_src_br   = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = rst_n;
                ir_en    = rst_n & bus.imem_ready;
            end
            S_EXEC: begin
                case (opc)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    OP_ADDI: begin
                        alu_op      = ALU_ADD;
                        alu_src_imm = 1'b1;
                    end
                    OP_BEQZ: begin
                        alu_op    = ALU_SUB;
                        pc_en     = 1'b1;
                        pc_src_br = bus.alu_zero;
                        retire    = 1'b1;
                    end
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OP_ST);
                if ((opc == OP_ST) && bus.dmem_ready) begin
                    pc_en  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                pc_en      = 1'b1;
                wb_sel_mem = (opc == OP_LD);
                retire     = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.imem_req    = imem_req;
    assign bus.ir_en       = ir_en;
    assign bus.pc_en       = pc_en;
    assign bus.pc_src_br   = pc_src_br;
    assign bus.alu_op      = alu_op;
    assign bus.alu_src_imm = alu_src_imm;
    assign bus.dmem_req    = dmem_req;
    assign bus.dmem_we     = dmem_we;
    assign bus.reg_we      = reg_we;
    assign bus.wb_sel_mem  = wb_sel_mem;
    assign bus.halted      = halted;

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .cnt   (bus.retired)
    );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected cycle traces built from the
// instruction-level rules, directed vectors, random instructions, reset and halt.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       imem_req;
        logic       ir_en;
        logic       pc_en;
        logic       pc_src_br;
        logic [1:0] alu_op;
        logic       alu_src_imm;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_we;
        logic       wb_sel_mem;
        logic       halted;
    } outs_t;

    typedef struct {
        logic  ir;
        logic  dr;
        logic  az;
        outs_t o;
        bit    retire;
    } cyc_t;

    typedef struct {
        logic [7:0] ins;
        int         idly;
        int         ddly;
        logic       zero;
        int         cyc;
        logic [1:0] alu;
        logic       pcsrc;
        int         regwe;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       alu_zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;

    mc_control_fsm_if #(.CNT_W(16)) if16 ();
    mc_control_fsm_if #(.CNT_W(2))  if2 ();

    assign if16.instr      = instr;
    assign if16.alu_zero   = alu_zero;
    assign if16.imem_ready = imem_ready;
    assign if16.dmem_ready = dmem_ready;
    assign if2.instr       = instr;
    assign if2.alu_zero    = alu_zero;
    assign if2.imem_ready  = imem_ready;
    assign if2.dmem_ready  = dmem_ready;

    mc_control_fsm #(.CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    mc_control_fsm #(.CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_cnt = 0;
    cyc_t       trace[$];
    logic [7:0] cur_ins;
    int         obs_pc_idx, obs_pc_cnt, obs_regwe;
    logic       obs_pcsrc;
    logic [1:0] obs_alu[$];
    vec_t       vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic outs_t dut_outs();
        outs_t o;
        o.imem_req    = if16.imem_req;
        o.ir_en       = if16.ir_en;
        o.pc_en       = if16.pc_en;
        o.pc_src_br   = if16.pc_src_br;
        o.alu_op      = if16.alu_op;
        o.alu_src_imm = if16.alu_src_imm;
        o.dmem_req    = if16.dmem_req;
        o.dmem_we     = if16.dmem_we;
        o.reg_we      = if16.reg_we;
        o.wb_sel_mem  = if16.wb_sel_mem;
        o.halted      = if16.halted;
        return o;
    endfunction

    function automatic cyc_t rnd_cyc();
        cyc_t c;
        c.ir     = 1'($urandom);
        c.dr     = 1'($urandom);
        c.az     = 1'($urandom);
        c.o      = '0;
        c.retire = 1'b0;
        return c;
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Expected cycle-by-cycle trace of one instruction: readies to drive and outputs to see.
    task automatic plan(input logic [7:0] ins, input int idly, input int ddly, input logic zero);
        logic [2:0] op;
        cyc_t       c;
        op = ins[7:5];
        cur_ins = ins;
        trace.delete();
        for (int k = 0; k < idly; k++) begin
            c = rnd_cyc(); c.ir = 1'b0; c.o.imem_req = 1'b1; trace.push_back(c);
        end
        c = rnd_cyc(); c.ir = 1'b1; c.o.imem_req = 1'b1; c.o.ir_en = 1'b1; trace.push_back(c);
        c = rnd_cyc(); trace.push_back(c);
        if (ins == 8'hE0 || (op == 3'b111 && ins[2:0] == 3'b000)) return;
        c = rnd_cyc();
        case (op)
            3'd0: c.o.alu_op = 2'b00;
            3'd1: c.o.alu_op = 2'b01;
            3'd2: c.o.alu_op = 2'b10;
            3'd3: c.o.alu_op = 2'b11;
            3'd4: c.o.alu_src_imm = 1'b1;
            3'd7: begin
                c.o.alu_op = 2'b01; c.o.pc_en = 1'b1; c.az = zero;
                c.o.pc_src_br = zero; c.retire = 1'b1;
            end
            default: ;
        endcase
        trace.push_back(c);
        if (op == 3'd5 || op == 3'd6) begin
            for (int k = 0; k < ddly; k++) begin
                c = rnd_cyc(); c.dr = 1'b0; c.o.dmem_req = 1'b1; c.o.dmem_we = (op == 3'd6);
                trace.push_back(c);
            end
            c = rnd_cyc(); c.dr = 1'b1; c.o.dmem_req = 1'b1; c.o.dmem_we = (op == 3'd6);
            if (op == 3'd6) begin c.o.pc_en = 1'b1; c.retire = 1'b1; end
            trace.push_back(c);
        end
        if (op != 3'd6 && op != 3'd7) begin
            c = rnd_cyc(); c.o.reg_we = 1'b1; c.o.pc_en = 1'b1;
            c.o.wb_sel_mem = (op == 3'd5); c.retire = 1'b1;
            trace.push_back(c);
        end
    endtask

    task automatic run_trace(input int limit);
        cyc_t  c;
        outs_t o;
        obs_pc_idx = 0; obs_pc_cnt = 0; obs_regwe = 0; obs_pcsrc = 1'b0;
        obs_alu.delete();
        for (int k = 0; k < trace.size() && k < limit; k++) begin
            c = trace[k];
            @(posedge clk); #1;
            instr = cur_ins; imem_ready = c.ir; dmem_ready = c.dr; alu_zero = c.az;
            @(negedge clk);
            o = dut_outs();
            chk("outs", 32'(o), 32'(c.o));
            chk("retired", 32'(if16.retired), exp_cnt);
            chk("retired_sat", 32'(if2.retired), sat3(exp_cnt));
            obs_alu.push_back(o.alu_op);
            if (o.pc_en) begin obs_pc_cnt++; obs_pc_idx = k + 1; obs_pcsrc = o.pc_src_br; end
            if (o.reg_we) obs_regwe++;
            if (c.retire) exp_cnt++;
        end
    endtask

    task automatic do_reset();
        outs_t e;
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 32'(dut_outs()), 0);
        chk("rst_retired", 32'(if16.retired), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        e = '0; e.imem_req = 1'b1;
        chk("post_rst_outs", 32'(dut_outs()), 32'(e));
        chk("post_rst_retired", 32'(if16.retired), 0);
        exp_cnt = 0;
    endtask

    initial begin
        outs_t e;
        logic [7:0] ri;
        vt[0]  = '{8'b000_01_010, 0, 0, 1'b0, 4, 2'b00, 1'b0, 1};
        vt[1]  = '{8'b101_10_001, 0, 3, 1'b0, 8, 2'b00, 1'b0, 1};
        vt[2]  = '{8'b111_01_111, 0, 0, 1'b1, 3, 2'b01, 1'b1, 0};
        vt[3]  = '{8'b111_01_111, 0, 0, 1'b0, 3, 2'b01, 1'b0, 0};
        vt[4]  = '{8'b110_01_011, 1, 2, 1'b0, 7, 2'b00, 1'b0, 0};
        vt[5]  = '{8'b001_11_100, 2, 0, 1'b0, 6, 2'b01, 1'b0, 1};
        vt[6]  = '{8'b010_00_001, 0, 0, 1'b0, 4, 2'b10, 1'b0, 1};
        vt[7]  = '{8'b011_10_110, 1, 0, 1'b0, 5, 2'b11, 1'b0, 1};
        vt[8]  = '{8'b100_01_101, 0, 0, 1'b0, 4, 2'b00, 1'b0, 1};
        vt[9]  = '{8'b101_00_010, 0, 0, 1'b0, 5, 2'b00, 1'b0, 1};
        vt[10] = '{8'b110_11_000, 0, 0, 1'b0, 4, 2'b00, 1'b0, 0};

        #2;
        do_reset();

        foreach (vt[i]) begin
            plan(vt[i].ins, vt[i].idly, vt[i].ddly, vt[i].zero);
            run_trace(1000);
            chk($sformatf("latency[%0d]", i), obs_pc_idx, vt[i].cyc);
            chk($sformatf("pc_en_count[%0d]", i), obs_pc_cnt, 1);
            chk($sformatf("exec_alu_op[%0d]", i), 32'(obs_alu[vt[i].idly + 2]), 32'(vt[i].alu));
            chk($sformatf("pc_src_br[%0d]", i), 32'(obs_pcsrc), 32'(vt[i].pcsrc));
            chk($sformatf("reg_we_count[%0d]", i), obs_regwe, vt[i].regwe);
        end

        for (int n = 0; n < 200; n++) begin
            ri = 8'($urandom);
            if (ri[7:5] == 3'b111 && ri[2:0] == 3'b000) ri[0] = 1'b1;
            plan(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
            run_trace(1000);
            chk("rand_pc_en_count", obs_pc_cnt, 1);
        end

        // Reset while a store is stalled waiting for dmem_ready.
        plan(8'b110_01_011, 0, 6, 1'b0);
        run_trace(5);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midst_rst_outs", 32'(dut_outs()), 0);
        chk("midst_rst_retired", 32'(if16.retired), 0);
        chk("midst_rst_retired_sat", 32'(if2.retired), 0);
        do_reset();

        // Five ADDs: the 2-bit counter must stick at its maximum.
        for (int k = 1; k <= 5; k++) begin
            plan(8'b000_01_010, 0, 0, 1'b0);
            run_trace(1000);
            @(posedge clk); #1;
            imem_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("add_retired[%0d]", k), 32'(if16.retired), k);
            chk($sformatf("add_retired_sat[%0d]", k), 32'(if2.retired), sat3(k));
        end

        // HALT is terminal: no fetch requests, no retire, regardless of readies.
        plan(8'hE0, 1, 0, 1'b0);
        run_trace(1000);
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); alu_zero = 1'($urandom);
            @(negedge clk);
            chk("halt_outs", 32'(dut_outs()), 32'(e));
            chk("halt_retired", 32'(if16.retired), exp_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
